// File: rtl/gpio_flt_pkg.sv
// Shared constants and the effective-filter-length helper for the GPIO input filter.
package gpio_flt_pkg;

  localparam int GPIO_FLT_MAX_BITS  = 32;
  localparam int GPIO_FLT_MAX_CNT_W = 32;

  // Lengths are widened to the maximum counter width so one helper serves any CNT_W.
  typedef logic [GPIO_FLT_MAX_CNT_W-1:0] flt_len_ext_t;

  function automatic flt_len_ext_t eff_len(input logic en, input flt_len_ext_t len);
    return (en && (len != '0)) ? len : flt_len_ext_t'(1);
  endfunction

endpackage

// File: rtl/gpio_flt_bit.sv
// One GPIO pin: two-flop synchroniser, stability counter, filtered level and edge pulses.
// Edge pulse flops exist only when GPIO_IN_FILTER_EDGE_EN is defined.
module gpio_flt_bit
  import gpio_flt_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pad,
  input  logic             flt_en,
  input  logic [CNT_W-1:0] flt_len,
  output logic             din,
  output logic             rise,
  output logic             fall
);

  typedef logic [CNT_W-1:0] flt_cnt_t;

  logic         s1;
  logic         s2;
  flt_cnt_t     cnt;
  flt_len_ext_t len_eff;
  logic         commit;

  assign len_eff = eff_len(flt_en, flt_len_ext_t'(flt_len));
  // Live threshold compare with >= so a lowered length commits an over-threshold count at once.
  assign commit  = (s2 != din) && (flt_len_ext_t'(cnt) >= (len_eff - flt_len_ext_t'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pad;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      din <= 1'b0;
    end else if (s2 == din) begin
      cnt <= '0;
    end else if (commit) begin
      din <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + flt_cnt_t'(1);
    end
  end

`ifdef GPIO_IN_FILTER_EDGE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= commit & s2;
      fall <= commit & ~s2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-pin synchroniser and glitch filter feeding gpioi_din.
// Define GPIO_IN_FILTER_EDGE_EN to build the rise_o/fall_o pulse flops; otherwise they are tied low.
module gpio_in_filter
  import gpio_flt_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NBITS-1:0] pad_i,
  input  logic [NBITS-1:0] flt_en_i,
  input  logic [CNT_W-1:0] flt_len_i,
  output logic [NBITS-1:0] din_o,
  output logic [NBITS-1:0] rise_o,
  output logic [NBITS-1:0] fall_o
);

  if (NBITS < 1 || NBITS > GPIO_FLT_MAX_BITS || CNT_W < 1 || CNT_W > GPIO_FLT_MAX_CNT_W) begin : g_param_check
    $error("gpio_in_filter: NBITS must be 1..32 and CNT_W 1..32");
  end

  for (genvar i = 0; i < NBITS; i++) begin : g_pin
    gpio_flt_bit #(
      .CNT_W(CNT_W)
    ) u_bit (
      .clk    (clk),
      .rstn   (rstn),
      .pad    (pad_i[i]),
      .flt_en (flt_en_i[i]),
      .flt_len(flt_len_i),
      .din    (din_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: directed scenarios plus random pads against a window model.
module tb_gpio_in_filter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] pad_i = '0;
  logic [7:0] flt_en_i = '0;
  logic [7:0] flt_len_i = '0;
  logic [7:0] din_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;

  int errors = 0;
  int checks = 0;

  // Model state: pad samples per edge, pre-edge synchronised levels per edge, expected outputs.
  logic [7:0] pad_q[$];
  logic [7:0] s2_q[$];
  logic [7:0] m_din;
  logic [7:0] m_rise;
  logic [7:0] m_fall;

  logic [7:0] rnd_pad;
  logic [7:0] flip;
  logic [7:0] en_r;
  logic [7:0] len_r;

  gpio_in_filter #(
    .NBITS(8),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .pad_i    (pad_i),
    .flt_en_i (flt_en_i),
    .flt_len_i(flt_len_i),
    .din_o    (din_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pad_q.delete();
    pad_q.push_back(8'h00);
    pad_q.push_back(8'h00);
    s2_q.delete();
    m_din  = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  // A pin commits when its last L synchronised samples (since reset) all differ from its level.
  task automatic modelEdge();
    logic [7:0] s2pre;
    logic [7:0] old;
    int         len_eff;
    int         run;
    int         k;
    s2pre = pad_q[pad_q.size() - 2];
    old   = m_din;
    pad_q.push_back(pad_i);
    s2_q.push_back(s2pre);
    for (int i = 0; i < 8; i++) begin
      len_eff = (flt_en_i[i] && flt_len_i != 0) ? int'(flt_len_i) : 1;
      run = 0;
      k = s2_q.size() - 1;
      while (k >= 0 && run < len_eff && s2_q[k][i] != old[i]) begin
        run++;
        k--;
      end
      if (run >= len_eff) m_din[i] = ~old[i];
    end
`ifdef GPIO_IN_FILTER_EDGE_EN
    m_rise = m_din & ~old;
    m_fall = ~m_din & old;
`else
    m_rise = '0;
    m_fall = '0;
`endif
  endtask

  task automatic applyStimulus(input logic [7:0] pad, input logic [7:0] en, input logic [7:0] len);
    @(negedge clk);
    pad_i     = pad;
    flt_en_i  = en;
    flt_len_i = len;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput({tag, ".din"}, din_o, m_din);
    checkOutput({tag, ".rise"}, rise_o, m_rise);
    checkOutput({tag, ".fall"}, fall_o, m_fall);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    modelReset();

    // Reset held with all pads high and filtering on: every output stays low.
    applyStimulus(8'hFF, 8'hFF, 8'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst.din", din_o, 8'h00);
      checkOutput("rst.rise", rise_o, 8'h00);
      checkOutput("rst.fall", fall_o, 8'h00);
    end
    @(negedge clk);
    rstn = 1'b1;
    ticks("rel", 5);
    checkOutput("rel.din_before6", din_o, 8'h00);
    tick("rel6");
    checkOutput("rel.din_at6", din_o, 8'hFF);
`ifdef GPIO_IN_FILTER_EDGE_EN
    checkOutput("rel.rise_at6", rise_o, 8'hFF);
`else
    checkOutput("rel.rise_at6", rise_o, 8'h00);
`endif
    tick("rel7");
    checkOutput("rel.rise_after", rise_o, 8'h00);

    // Bring everything low, then a 3-cycle glitch on pin 2 must be rejected.
    applyStimulus(8'h00, 8'hFF, 8'd4);
    ticks("low", 7);
    checkOutput("low.din", din_o, 8'h00);
    applyStimulus(8'h04, 8'hFF, 8'd4);
    ticks("glitch", 3);
    applyStimulus(8'h00, 8'hFF, 8'd4);
    ticks("glitch", 8);
    checkOutput("glitch.din", din_o, 8'h00);

    // A 4-cycle pulse on pin 2 passes, producing a 4-cycle high level.
    applyStimulus(8'h04, 8'hFF, 8'd4);
    ticks("pulse", 4);
    applyStimulus(8'h00, 8'hFF, 8'd4);
    ticks("pulse", 10);

    // Pin 5 bypassed with a long shared length: follows every toggle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 8'h20 : 8'h00, 8'hDF, 8'd200);
      tick("bypass");
    end
    applyStimulus(8'h00, 8'hDF, 8'd200);
    ticks("bypass", 4);
    checkOutput("bypass.settle", din_o, 8'h00);

    // Length 10, mismatch held until cnt=6, then drop length to 3: commit on next edge.
    applyStimulus(8'h01, 8'hFF, 8'd10);
    ticks("lenchg", 8);
    checkOutput("lenchg.before", din_o, 8'h00);
    applyStimulus(8'h01, 8'hFF, 8'd3);
    tick("lenchg");
    checkOutput("lenchg.after", din_o, 8'h01);

    // Pin 1 mid-count (cnt=5) when reset asserts asynchronously.
    applyStimulus(8'h02, 8'hFF, 8'd8);
    ticks("midcnt", 7);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async.din", din_o, 8'h00);
    checkOutput("async.rise", rise_o, 8'h00);
    checkOutput("async.fall", fall_o, 8'h00);
    modelReset();
    @(negedge clk);
    rstn = 1'b1;
    ticks("rel2", 9);
    checkOutput("rel2.before", din_o, 8'h00);
    tick("rel2");
    checkOutput("rel2.after", din_o, 8'h02);

    // Random pads with occasional enable and length changes.
    rnd_pad = 8'h02;
    en_r    = 8'hFF;
    len_r   = 8'd3;
    for (int c = 0; c < 600; c++) begin
      flip = '0;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 4) == 0) flip[b] = 1'b1;
      end
      rnd_pad = rnd_pad ^ flip;
      if ($urandom_range(0, 29) == 0) en_r = 8'($urandom);
      if ($urandom_range(0, 19) == 0) len_r = 8'($urandom_range(0, 5));
      applyStimulus(rnd_pad, en_r, len_r);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
